// File: rtl/dma_engine.sv
// dma_engine: single-channel word COPY / ZERO-FILL engine on a req/gnt data-memory master port.
module dma_engine #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 12
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            dma_en_i,
    input  logic [2:0]      dma_funct3_i,
    input  logic [11:0]     dma_imm_i,
    input  logic [XLEN-1:0] dma_rs1_i,
    input  logic [XLEN-1:0] dma_rs2_i,
    output logic            dma_busy_o,
    output logic            dma_done_o,
    output logic            mem_req_o,
    input  logic            mem_gnt_i,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic [XLEN-1:0] mem_rd_data_i,
    output logic [XLEN-1:0] mem_wr_data_o,
    output logic [3:0]      mem_size_o,
    output logic            mem_read_o,
    output logic            mem_write_o
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RD    = 2'd1;
    localparam logic [1:0] S_RWAIT = 2'd2;
    localparam logic [1:0] S_WR    = 2'd3;

    logic [1:0]       r_state;
    logic [XLEN-1:0]  r_src;
    logic [XLEN-1:0]  r_dst;
    logic [XLEN-1:0]  r_buf;
    logic [CNT_W-1:0] r_cnt;
    logic             r_fill;
    logic             r_ign;
    logic             w_idle;
    logic             w_valid;
    logic             w_start;
    logic             w_last;

    assign w_idle  = r_state == S_IDLE;
    assign w_valid = dma_funct3_i[2:1] == 2'b00 && dma_imm_i[CNT_W-1:0] != '0;
    assign w_start = w_idle && dma_en_i && w_valid;
    assign w_last  = r_state == S_WR && mem_gnt_i && r_cnt == CNT_W'(1);

    assign dma_busy_o    = !w_idle;
    // Final-write done is combinational with the grant; ignored commands pulse a cycle later.
    assign dma_done_o    = w_last || r_ign;
    assign mem_req_o     = r_state == S_RD || r_state == S_WR;
    assign mem_read_o    = r_state == S_RD;
    assign mem_write_o   = r_state == S_WR;
    assign mem_size_o    = mem_req_o ? 4'b1111 : 4'b0000;
    assign mem_addr_o    = mem_write_o ? r_dst : mem_read_o ? r_src : '0;
    assign mem_wr_data_o = mem_write_o && !r_fill ? r_buf : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_buf   <= '0;
            r_cnt   <= '0;
            r_fill  <= 1'b0;
            r_ign   <= 1'b0;
        end else begin
            r_ign <= w_idle && dma_en_i && !w_valid;
            case (r_state)
                S_IDLE: if (w_start) begin
                    r_src   <= {dma_rs1_i[XLEN-1:2], 2'b00};
                    r_dst   <= {dma_rs2_i[XLEN-1:2], 2'b00};
                    r_cnt   <= dma_imm_i[CNT_W-1:0];
                    r_fill  <= dma_funct3_i[0];
                    r_state <= dma_funct3_i[0] ? S_WR : S_RD;
                end
                S_RD: if (mem_gnt_i) r_state <= S_RWAIT;
                S_RWAIT: begin
                    r_buf   <= mem_rd_data_i;
                    r_state <= S_WR;
                end
                default: if (mem_gnt_i) begin
                    r_dst   <= r_dst + XLEN'(4);
                    r_src   <= r_fill ? r_src : r_src + XLEN'(4);
                    r_cnt   <= r_cnt - CNT_W'(1);
                    r_state <= w_last ? S_IDLE : r_fill ? S_WR : S_RD;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dma_engine.sv
// tb_dma_engine: directed checks of COPY, FILL, grant stalls, ignored commands, reset abort and wrap.
module tb_dma_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [2:0]  f3 = '0;
    logic [11:0] imm = '0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        gnt = 1'b1;
    logic [31:0] rd_data = '0;
    logic        busy, done, req, rd, wr;
    logic [31:0] addr, wdata;
    logic [3:0]  size;

    dma_engine dut (
        .clk_i(clk), .rst_i(rst), .dma_en_i(en), .dma_funct3_i(f3), .dma_imm_i(imm),
        .dma_rs1_i(rs1), .dma_rs2_i(rs2), .dma_busy_o(busy), .dma_done_o(done),
        .mem_req_o(req), .mem_gnt_i(gnt), .mem_addr_o(addr), .mem_rd_data_i(rd_data),
        .mem_wr_data_o(wdata), .mem_size_o(size), .mem_read_o(rd), .mem_write_o(wr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    logic [31:0] mem [logic [31:0]];
    logic [31:0] rd_q[$], wa_q[$], wd_q[$];
    int busy_cnt, done_cnt, done_busy, req_cnt;
    logic        p_wait = 1'b0;
    logic [31:0] p_addr, p_wd;
    logic [2:0]  p_ctl;

    always @(posedge clk)
        if (req && gnt && rd) rd_data <= mem.exists(addr) ? mem[addr] : 32'h0;

    always @(negedge clk) begin
        chk("rw_excl", {31'b0, rd & wr}, 32'h0);
        if (!req) chk("idle_ctl", {27'b0, size, rd | wr}, 32'h0);
        if (p_wait && !rst) begin
            chk("hold_addr", addr, p_addr);
            chk("hold_ctl", {29'b0, req, rd, wr}, {29'b0, p_ctl});
            chk("hold_wd", wdata, p_wd);
        end
        p_wait = req && !gnt;
        p_addr = addr;
        p_wd   = wdata;
        p_ctl  = {req, rd, wr};
        if (busy) busy_cnt++;
        if (req) req_cnt++;
        if (done) begin
            done_cnt++;
            done_busy = busy_cnt;
        end
        if (req && gnt && rd) rd_q.push_back(addr);
        if (req && gnt && wr) begin
            wa_q.push_back(addr);
            wd_q.push_back(wdata);
        end
    end

    task automatic clr();
        rd_q.delete(); wa_q.delete(); wd_q.delete();
        busy_cnt = 0; done_cnt = 0; done_busy = 0; req_cnt = 0;
    endtask

    task automatic cmd(input logic [2:0] f, input logic [11:0] n, input logic [31:0] s, input logic [31:0] d);
        @(posedge clk); #1;
        en = 1'b1; f3 = f; imm = n; rs1 = s; rs2 = d;
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int k = 0;
        while (done_cnt == 0 && k < limit) begin
            @(posedge clk);
            k++;
        end
        if (k >= limit) chk("done_timeout", 32'(k), 32'(limit - 1));
        repeat (3) @(posedge clk);
    endtask

    initial begin
        mem[32'h1000_0000] = 32'hA;
        mem[32'h1000_0004] = 32'hB;
        mem[32'h1000_0008] = 32'hC;
        mem[32'h4000_0000] = 32'h1111;
        mem[32'h4000_0004] = 32'h2222;
        #12;
        chk("rst_outs", {busy, done, req, rd, wr, size, 23'b0}, 32'h0);
        chk("rst_addr", addr, 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        clr();
        cmd(3'b000, 12'd3, 32'h1000_0003, 32'h2000_0000);
        wait_done(50);
        chk("copy_nrd", 32'(rd_q.size()), 3);
        chk("copy_nwr", 32'(wa_q.size()), 3);
        for (int i = 0; i < 3 && i < rd_q.size() && i < wa_q.size(); i++) begin
            chk("copy_ra", rd_q[i], 32'h1000_0000 + 32'(4 * i));
            chk("copy_wa", wa_q[i], 32'h2000_0000 + 32'(4 * i));
            chk("copy_wd", wd_q[i], 32'hA + 32'(i));
        end
        chk("copy_busy", 32'(busy_cnt), 9);
        chk("copy_done", 32'(done_cnt), 1);
        chk("copy_done_at", 32'(done_busy), 9);

        clr();
        cmd(3'b001, 12'd4, 32'h0, 32'h3000_0010);
        wait_done(50);
        chk("fill_nrd", 32'(rd_q.size()), 0);
        chk("fill_nwr", 32'(wa_q.size()), 4);
        for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
            chk("fill_wa", wa_q[i], 32'h3000_0010 + 32'(4 * i));
            chk("fill_wd", wd_q[i], 32'h0);
        end
        chk("fill_busy", 32'(busy_cnt), 4);
        chk("fill_done_at", 32'(done_busy), 4);

        clr();
        gnt = 1'b0;
        cmd(3'b000, 12'd2, 32'h4000_0000, 32'h5000_0000);
        repeat (5) @(posedge clk); #1 gnt = 1'b1;
        repeat (5) @(posedge clk); #1 gnt = 1'b0;
        repeat (3) @(posedge clk); #1 gnt = 1'b1;
        wait_done(50);
        chk("stall_nwr", 32'(wa_q.size()), 2);
        if (wa_q.size() == 2) begin
            chk("stall_wa0", wa_q[0], 32'h5000_0000);
            chk("stall_wd0", wd_q[0], 32'h1111);
            chk("stall_wa1", wa_q[1], 32'h5000_0004);
            chk("stall_wd1", wd_q[1], 32'h2222);
        end
        chk("stall_busy", 32'(busy_cnt), 14);
        chk("stall_done", 32'(done_cnt), 1);

        clr();
        cmd(3'b000, 12'd0, 32'h1000_0000, 32'h2000_0000);
        wait_done(10);
        chk("imm0_req", 32'(req_cnt), 0);
        chk("imm0_busy", 32'(busy_cnt), 0);
        chk("imm0_done", 32'(done_cnt), 1);
        clr();
        cmd(3'b111, 12'd5, 32'h1000_0000, 32'h2000_0000);
        wait_done(10);
        chk("rsv_req", 32'(req_cnt), 0);
        chk("rsv_busy", 32'(busy_cnt), 0);
        chk("rsv_done", 32'(done_cnt), 1);

        clr();
        cmd(3'b000, 12'd10, 32'h1000_0000, 32'h7000_0000);
        for (int k = 0; k < 20 && !wr; k++) @(negedge clk);
        chk("rst_in_wr", {31'b0, wr}, 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("arst_outs", {busy, done, req, rd, wr, size, 23'b0}, 32'h0);
        chk("arst_addr", addr, 32'h0);
        chk("arst_wd", wdata, 32'h0);
        repeat (3) @(posedge clk);
        chk("arst_nodone", 32'(done_cnt), 0);
        #1 rst = 1'b0;
        clr();
        cmd(3'b000, 12'd1, 32'h1000_0000, 32'h6000_0000);
        wait_done(20);
        chk("post_nwr", 32'(wa_q.size()), 1);
        if (wa_q.size() == 1) begin
            chk("post_wa", wa_q[0], 32'h6000_0000);
            chk("post_wd", wd_q[0], 32'hA);
        end
        chk("post_busy", 32'(busy_cnt), 3);

        clr();
        cmd(3'b001, 12'd4, 32'h0, 32'hFFFF_FFF8);
        wait_done(20);
        chk("wrap_nwr", 32'(wa_q.size()), 4);
        if (wa_q.size() == 4) begin
            chk("wrap_a0", wa_q[0], 32'hFFFF_FFF8);
            chk("wrap_a1", wa_q[1], 32'hFFFF_FFFC);
            chk("wrap_a2", wa_q[2], 32'h0000_0000);
            chk("wrap_a3", wa_q[3], 32'h0000_0004);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dma_engine.md
Name: dma_engine

Overview:
- Single-channel memory-to-memory DMA engine downstream of the core's EX stage.
- Consumes the one-cycle DMA command (enable, funct3, imm, rs1, rs2) issued by the core.
- Performs word transfers on a req/gnt data-memory master port and drives the busy flag the core uses to stall.
- Shares the data memory with the core through the external arbiter.

Parameters:
XLEN, 32, data and address width
CNT_W, 12, width of the word-count field, taken from imm[CNT_W-1:0]

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
dma_en_i  in  1  command strobe from the core (one cycle per command)
dma_funct3_i  in  3  operation: 3'b000 COPY, 3'b001 ZERO-FILL, others reserved
dma_imm_i  in  12  word count
dma_rs1_i  in  XLEN  source address (COPY only)
dma_rs2_i  in  XLEN  destination address
dma_busy_o  out  1  engine active; core stalls while high
dma_done_o  out  1  one-cycle pulse when the last write is granted
mem_req_o  out  1  request for the data memory
mem_gnt_i  in  1  grant; the access occurs in the granted cycle
mem_addr_o  out  XLEN  word address, [1:0] always 2'b00
mem_rd_data_i  in  XLEN  read data, valid the cycle after a granted read
mem_wr_data_o  out  XLEN  write data
mem_size_o  out  4  byte enables, always 4'b1111 when active, else 0
mem_read_o  out  1  read access
mem_write_o  out  1  write access

Behaviour:
- Reset (asynchronous, active-high): state IDLE. All outputs are 0. Address, count and buffer registers are cleared. Reset mid-transfer aborts immediately with no done pulse.
- IDLE, with dma_en_i=1, funct3 in {000, 001}, and imm!=0:
  - latch src=rs1&~3, dst=rs2&~3, cnt=imm, op.
  - dma_busy_o is high from the next edge.
  - Next state is RD for COPY, WR for FILL.
- IDLE, with dma_en_i=1 and (imm==0 or funct3 reserved): command ignored, busy stays 0, dma_done_o pulses 1 cycle after.
- dma_en_i is ignored in every state other than IDLE.
- RD: mem_req_o=1, mem_read_o=1, mem_addr_o=src, mem_size_o=4'b1111. On mem_gnt_i go to RWAIT; otherwise hold all outputs stable.
- RWAIT: no request. Capture mem_rd_data_i into buf. Go to WR.
- WR: mem_req_o=1, mem_write_o=1, mem_addr_o=dst, mem_wr_data_o = buf (COPY) or 0 (FILL). On mem_gnt_i:
  - dst+=4, src+=4 (COPY only), cnt-=1.
  - If cnt was 1: go to IDLE, pulse dma_done_o in the same cycle the grant is seen, and drop busy at that edge (busy=0 the next cycle).
  - Otherwise go to RD (COPY) or stay in WR (FILL).
- Throughput:
  - COPY is 3 cycles/word with a continuous grant.
  - FILL is 1 cycle/word.
  - Total busy cycles for COPY with N words and no grant stalls = 3N.
- Addresses wrap modulo 2^XLEN with no error.
- mem_req_o is held high without gaps until granted; address, data and control do not change while waiting.
- dma_busy_o is a registered output: high in every cycle from the one after the strobe through the cycle of the final write grant inclusive.
- mem_read_o and mem_write_o are never both 1. mem_req_o=0 implies read=write=0.

Test Plan:
- COPY, rs1=0x1000_0003, rs2=0x2000_0000, imm=3, memory holds 0xA,0xB,0xC at 0x1000_0000..08, grant always 1:
  - reads 0x1000_0000/04/08 and writes 0xA,0xB,0xC to 0x2000_0000/04/08.
  - busy high for exactly 9 cycles, one done pulse on the 9th.
- FILL, rs2=0x3000_0010, imm=4, grant always 1: four consecutive write cycles of 0 to 0x3000_0010..1C, busy for 4 cycles.
- COPY of 2 words with mem_gnt_i low for 5 cycles during the first RD and 3 cycles during the second WR:
  - request signals are held stable while waiting.
  - busy lasts 6+8 = 14 cycles.
  - data is correct.
- imm=0, and separately funct3=3'b111, with dma_en_i pulsed: no memory request, busy stays 0, done pulses once.
- rst_i asserted while in WR of a 10-word COPY: all outputs are 0 asynchronously and no done pulse; a new COPY after release runs normally from IDLE.
- FILL with rs2=0xFFFF_FFF8, imm=4: writes to 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.
